// File: rtl/key_switch_input_pio.sv
// Avalon-MM input PIO: synchronised, debounced board inputs with edge capture and a maskable irq.
// Latency: pin to DATA is SYNC_STAGES+DEBOUNCE_CYCLES cycles; readdata 1 cycle after read; irq 1 cycle after capture&mask.
// Backpressure: none, since the slave always accepts and has no waitrequest.
module key_switch_input_pio #(
  parameter int DATA_WIDTH      = 10,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic                  avs_chipselect,
  input  logic [1:0]            avs_address,
  input  logic                  avs_read,
  input  logic                  avs_write,
  input  logic [31:0]           avs_writedata,
  output logic [31:0]           avs_readdata,
  output logic                  irq,
  input  logic [DATA_WIDTH-1:0] pins_in
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [CNT_W-1:0]      cnt     [DATA_WIDTH];
  logic [CNT_W-1:0]      cnt_nxt [DATA_WIDTH];
  logic [DATA_WIDTH-1:0] sync;
  logic [DATA_WIDTH-1:0] stable;
  logic [DATA_WIDTH-1:0] mask;
  logic [DATA_WIDTH-1:0] capture;
  logic [DATA_WIDTH-1:0] polarity;
  logic [DATA_WIDTH-1:0] accept;
  logic [DATA_WIDTH-1:0] edge_set;
  logic [DATA_WIDTH-1:0] clr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [31:0]           rd_mux;
  logic                  wr_en;
  logic                  rd_en;

  assign sync  = sync_q[SYNC_STAGES-1];
  assign wr_en = avs_chipselect & avs_write;
  assign rd_en = avs_chipselect & avs_read;
  assign wdata = avs_writedata[DATA_WIDTH-1:0];

  generate
    if (DATA_WIDTH < 32) begin : g_wdata_hi
      logic unused_wdata_hi;
      assign unused_wdata_hi = ^avs_writedata[31:DATA_WIDTH];
    end
  endgenerate

  // Any return to the stable level clears the count, so a glitch shorter than the window is dropped.
  always_comb begin
    accept = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      cnt_nxt[i] = '0;
      if (sync[i] != stable[i]) begin
        if (cnt[i] == CNT_LAST) accept[i] = 1'b1;
        else                    cnt_nxt[i] = cnt[i] + 1'b1;
      end
    end
  end

  // The accepted new level equals sync; it is an edge of interest when it differs from polarity.
  assign edge_set = accept & (sync ^ polarity);
  assign clr      = (wr_en && avs_address == 2'd2) ? wdata : '0;

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      2'd0:    rd_mux[DATA_WIDTH-1:0] = stable;
      2'd1:    rd_mux[DATA_WIDTH-1:0] = mask;
      2'd2:    rd_mux[DATA_WIDTH-1:0] = capture;
      default: rd_mux[DATA_WIDTH-1:0] = polarity;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      for (int i = 0; i < DATA_WIDTH; i++)  cnt[i]    <= '0;
      stable       <= '0;
      mask         <= '0;
      capture      <= '0;
      polarity     <= '0;
      avs_readdata <= '0;
      irq          <= 1'b0;
    end else begin
      sync_q[0] <= pins_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      for (int i = 0; i < DATA_WIDTH; i++)  cnt[i]    <= cnt_nxt[i];
      stable  <= stable ^ accept;
      // Set is ORed in after the clear so a same-cycle edge survives the W1C.
      capture <= (capture & ~clr) | edge_set;
      if (wr_en && avs_address == 2'd1) mask     <= wdata;
      if (wr_en && avs_address == 2'd3) polarity <= wdata;
      if (rd_en) avs_readdata <= rd_mux;
      irq <= |(capture & mask);
    end
  end

endmodule
